iter_shifter: RTL

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 32 +++
 rtl/iter_shifter.sv | 110 +++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: operation encoding and FSM states.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift of 0..STEP bit positions in the selected mode.
// Rotate support is built only when ITER_SHIFTER_ROTATE_EN is defined.
module shift_step
    import shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 6
) (
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  mode_e             mode,
    output logic [DATA_W-1:0] result
);

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        result = data;
        case (mode)
            MODE_SLL: result = data << amt;
            MODE_SRL: result = data >> amt;
            // The working register keeps its MSB under SRA, so it is the operand's sign.
            MODE_SRA: result = $signed(data) >>> amt;
`ifdef ITER_SHIFTER_ROTATE_EN
            MODE_ROR: result = (data >> amt) | (data << (DATA_W - int'(amt)));
`else
            MODE_ROR: result = data;
`endif
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts up to STEP positions per clock with a valid/ready
// handshake on both sides. Optional rotate mode via ITER_SHIFTER_ROTATE_EN.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_data
);

    // One extra bit so STEP == DATA_W is representable.
    localparam int                AMT_W    = SHAMT_W + 1;
    localparam logic [AMT_W-1:0]  STEP_AMT = AMT_W'(STEP);

    state_e             state;
    mode_e              mode;
    logic [DATA_W-1:0]  work;
    logic [SHAMT_W-1:0] remaining;
    logic [AMT_W-1:0]   step_amt;
    logic               last_step;
    logic               direct_done;
    logic [DATA_W-1:0]  step_result;

    always_comb begin
        step_amt  = ({1'b0, remaining} < STEP_AMT) ? {1'b0, remaining} : STEP_AMT;
        last_step = ({1'b0, remaining} <= STEP_AMT);
    end

`ifdef ITER_SHIFTER_ROTATE_EN
    assign direct_done = (i_shamt == '0);
`else
    // Without rotate support, mode 11 is a one-cycle pass-through.
    assign direct_done = (i_shamt == '0) || (mode_e'(i_mode) == MODE_ROR);
`endif

    shift_step #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift_step (
        .data   (work),
        .amt    (step_amt),
        .mode   (mode),
        .result (step_result)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            mode      <= MODE_SLL;
            work      <= '0;
            remaining <= '0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        work      <= i_data;
                        remaining <= i_shamt;
                        mode      <= mode_e'(i_mode);
                        o_ready   <= 1'b0;
                        if (direct_done) begin
                            o_data  <= i_data;
                            o_valid <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= step_result;
                    remaining <= remaining - step_amt[SHAMT_W-1:0];
                    if (last_step) begin
                        o_data  <= step_result;
                        o_valid <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
